// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to an external combinational
// 16-bit ALU. Operands come from an internal 8x16 register file and are held on
// the ALU inputs for SETTLE_CYCLES cycles. The controller then writes the
// result back to the register file, or to the HI/LO or status registers,
// depending on the opcode.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [2:0]  instr_rd,
  input  logic [2:0]  instr_rs,
  input  logic [2:0]  instr_rt,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_hi,
  input  logic [15:0] alu_low,
  input  logic [15:0] alu_status,
  output logic [15:0] hi_q,
  output logic [15:0] lo_q,
  output logic [15:0] status_q,
  input  logic [2:0]  rd_dbg_addr,
  output logic [15:0] rd_dbg_data,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WB} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] hi_d, lo_d, status_d;
  logic        done_q, done_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  // Only the flag nibble of the ALU status bus is meaningful.
  logic unused_status_bits;
  assign unused_status_bits = ^alu_status[11:0];

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign instr_ready = (state_q == IDLE);
  assign rd_dbg_data = regs_q[rd_dbg_addr];

  // Next-state: sequencing, operand issue, direct loads and writeback.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    status_d = status_q;
    done_d   = 1'b0;
    regs_d   = regs_q;

    // Direct load first, so a same-address writeback below overrides it.
    if (ld_en) regs_d[ld_addr] = ld_data;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_a_d  = regs_q[instr_rs];
          alu_b_d  = regs_q[instr_rt];
          alu_op_d = instr_op;
          rd_d     = instr_rd;
          cnt_d    = 4'(SETTLE_CYCLES - 1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = WB;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = WB;
          done_d  = 1'b1;
        end
      end
      WB: begin
        state_d = IDLE;
        case (alu_op_q)
          3'b000:                 regs_d[rd_q] = '0;
          3'b001, 3'b010: begin
            regs_d[rd_q] = alu_result;
            status_d     = {status_q[15:14], alu_status[13:12], 12'h000};
          end
          3'b011, 3'b100, 3'b101: regs_d[rd_q] = alu_result;
          3'b110: begin
            hi_d = alu_hi;
            lo_d = alu_low;
          end
          default:                status_d = {alu_status[15:12], 12'h000};
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      status_q <= status_d;
      done_q   <= done_d;
      regs_q   <= regs_d;
    end
  end

endmodule
